// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

  // Sequencer states: normal flow, waiting on data memory, timed-out.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  // Register $zero never creates a true dependency.
  localparam logic [4:0] REG_ZERO  = 5'd0;

  // Default width of the debug event counters.
  localparam int         CNT_W_DEF = 16;

  // Width of the memory wait counter; covers timeouts up to 255.
  localparam int         WAIT_W    = 8;

  // Load in ID/EX writes a register that the instruction in IF/ID reads.
  function automatic logic load_use_hit(input logic       ld_memread,
                                        input logic [4:0] ld_rt,
                                        input logic [4:0] use_rs,
                                        input logic [4:0] use_rt);
    return ld_memread && (ld_rt != REG_ZERO) &&
           ((ld_rt == use_rs) || (ld_rt == use_rt));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;

  // Count up on each enabled cycle, holding at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {WIDTH{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencer for the 5-stage pipeline: pipeline-register enables and
// flushes, load-use stalls, MEM-stage branch resolution, data-memory freeze.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rt_i,
  input  logic             exmem_memread_i,
  input  logic             exmem_memwrite_i,
  input  logic             exmem_branch_i,
  input  logic             exmem_zero_i,
  input  logic             dmem_ready_i,
  output logic             pc_we_o,
  output logic             ifid_we_o,
  output logic             idex_we_o,
  output logic             exmem_we_o,
  output logic             memwb_we_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             exmem_flush_o,
  output logic             pc_src_o,
  output logic             dmem_req_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [WAIT_W-1:0] LP_TIMEOUT = WAIT_W'(MEM_TIMEOUT);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic              r_mem_err;
  logic              w_err_nxt;

  logic w_mem_op;
  logic w_taken;
  logic w_load_use;

  assign w_mem_op   = exmem_memread_i | exmem_memwrite_i;
  assign w_taken    = exmem_branch_i & exmem_zero_i;
  assign w_load_use = load_use_hit(idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i);

  // Decode state and hazards into pipe controls and the next sequencer state.
  always_comb begin
    pc_we_o       = 1'b1;
    ifid_we_o     = 1'b1;
    idex_we_o     = 1'b1;
    exmem_we_o    = 1'b1;
    memwb_we_o    = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    exmem_flush_o = 1'b0;
    pc_src_o      = 1'b0;
    dmem_req_o    = 1'b0;
    w_state_nxt   = r_state;
    w_wait_nxt    = r_wait_cnt;
    w_err_nxt     = r_mem_err;

    // While reset is held the pipe free-runs and any memory access is dropped.
    if (rst_n) begin
      case (r_state)
        RUN: begin
          dmem_req_o = w_mem_op;
          if (w_mem_op && !dmem_ready_i) begin
            pc_we_o     = 1'b0;
            ifid_we_o   = 1'b0;
            idex_we_o   = 1'b0;
            exmem_we_o  = 1'b0;
            memwb_we_o  = 1'b0;
            w_state_nxt = MEM_WAIT;
            w_wait_nxt  = WAIT_W'(1);
          end else if (w_taken) begin
            // The squashed load makes any concurrent load-use match irrelevant.
            pc_src_o      = 1'b1;
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
            exmem_flush_o = 1'b1;
          end else if (w_load_use) begin
            // One bubble suffices: next cycle the load sits in EX/MEM.
            pc_we_o      = 1'b0;
            ifid_we_o    = 1'b0;
            idex_flush_o = 1'b1;
          end
        end
        MEM_WAIT: begin
          dmem_req_o = w_mem_op;
          pc_we_o    = 1'b0;
          ifid_we_o  = 1'b0;
          idex_we_o  = 1'b0;
          exmem_we_o = 1'b0;
          memwb_we_o = 1'b0;
          if (dmem_ready_i) begin
            w_state_nxt = RUN;
          end else if (r_wait_cnt == LP_TIMEOUT) begin
            w_state_nxt = ERR;
            w_err_nxt   = 1'b1;
          end else begin
            w_wait_nxt = r_wait_cnt + 1'b1;
          end
        end
        ERR: begin
          pc_we_o    = 1'b0;
          ifid_we_o  = 1'b0;
          idex_we_o  = 1'b0;
          exmem_we_o = 1'b0;
          memwb_we_o = 1'b0;
        end
        default: begin
          pc_we_o     = 1'b0;
          ifid_we_o   = 1'b0;
          idex_we_o   = 1'b0;
          exmem_we_o  = 1'b0;
          memwb_we_o  = 1'b0;
          w_state_nxt = RUN;
        end
      endcase
    end
  end

  // Sequencer state, memory wait counter and sticky timeout flag.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_mem_err  <= w_err_nxt;
    end
  end

  assign mem_err_o = r_mem_err;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .i_clk   (clk_i),
    .i_rst_n (rst_n),
    .i_inc   (~pc_we_o),
    .o_cnt   (stall_cnt_o)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .i_clk   (clk_i),
    .i_rst_n (rst_n),
    .i_inc   (pc_src_o),
    .o_cnt   (flush_cnt_o)
  );

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline: drives the write-enable and flush of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and resolves taken branches at the MEM stage, using the EX/MEM branch and zero outputs.
- Handshakes with a variable-latency data memory, freezing the whole pipe while an access is outstanding.
- Keeps saturating stall and flush event counters for debug.

Parameters:
- CNT_W, 16, width of the stall and flush counters.
- MEM_TIMEOUT, 15, maximum wait cycles for a data-memory access before an error is flagged; range 1..255.

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ifid_rs_i  in  5  rs field of the instruction in IF/ID.
- ifid_rt_i  in  5  rt field of the instruction in IF/ID.
- idex_memread_i  in  1  memread of the instruction in ID/EX.
- idex_rt_i  in  5  destination of the load in ID/EX.
- exmem_memread_i  in  1  EX/MEM memread output.
- exmem_memwrite_i  in  1  EX/MEM memwrite output.
- exmem_branch_i  in  1  EX/MEM branch output.
- exmem_zero_i  in  1  EX/MEM zero output.
- dmem_ready_i  in  1  data memory has completed the current access.
- pc_we_o  out  1  PC write enable.
- ifid_we_o  out  1  IF/ID write enable.
- idex_we_o  out  1  ID/EX write enable.
- exmem_we_o  out  1  EX/MEM write enable.
- memwb_we_o  out  1  MEM/WB write enable.
- ifid_flush_o  out  1  load a bubble into IF/ID.
- idex_flush_o  out  1  load a bubble into ID/EX.
- exmem_flush_o  out  1  load a bubble into EX/MEM.
- pc_src_o  out  1  select the branch target (EX/MEM branch_data) for the PC.
- dmem_req_o  out  1  data memory access request.
- mem_err_o  out  1  sticky timeout error.
- stall_cnt_o  out  CNT_W  saturating count of stall cycles.
- flush_cnt_o  out  CNT_W  saturating count of branch flushes.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to RUN; counters, wait counter and mem_err_o are cleared.
  - Outputs while in reset: all *_we_o=1, all flushes=0, pc_src_o=0, dmem_req_o=0.
- States: RUN, MEM_WAIT, ERR.
- mem_op = exmem_memread_i | exmem_memwrite_i.
- dmem_req_o = mem_op whenever the state is RUN or MEM_WAIT.
- RUN:
  - Priority 1, memory stall:
    - Condition: mem_op and !dmem_ready_i.
    - All *_we_o=0, no flushes, pc_src_o=0.
    - Next state MEM_WAIT; wait counter loads 1.
  - Priority 2, taken branch:
    - Condition: exmem_branch_i & exmem_zero_i.
    - pc_src_o=1; ifid_flush_o, idex_flush_o and exmem_flush_o all 1.
    - All *_we_o=1; flush_cnt_o increments.
    - Any load-use hazard in the same cycle is ignored, because the load is squashed.
  - Priority 3, load-use hazard:
    - Condition: idex_memread_i, idex_rt_i!=0, and idex_rt_i equals ifid_rs_i or ifid_rt_i.
    - pc_we_o=0, ifid_we_o=0, idex_flush_o=1; the other enables stay 1.
    - Exactly one bubble is inserted: the next cycle the load has moved to EX/MEM, so the condition clears naturally.
  - Otherwise all *_we_o=1 and no flushes.
- MEM_WAIT:
  - All *_we_o=0 and all flushes=0; pc_src_o=0.
  - If dmem_ready_i=1: return to RUN. The comparison-driven outputs of RUN are evaluated from the next cycle; the pipe advances one cycle later.
  - Else if the wait counter equals MEM_TIMEOUT: go to ERR and set mem_err_o.
  - Else the wait counter increments.
- ERR:
  - All *_we_o=0, dmem_req_o=0; the state is held until reset.
  - mem_err_o stays 1.
- stall_cnt_o increments on every cycle in which pc_we_o=0, which includes MEM_WAIT and ERR cycles.
- Both counters saturate at 2^CNT_W-1.
- Reset asserted mid-wait aborts the access immediately: dmem_req_o goes to 0 asynchronously.
- Outputs are combinational from state plus inputs; there is no added latency.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state enum {RUN, MEM_WAIT, ERR};
  - REG_ZERO=5'd0 constant;
  - localparam for the counter width.
- One natural sub-module, sat_counter: parameterised width, inc, async active-low clear. It is instantiated for the stall counter and the flush counter; the wait counter is internal.

Test Plan:
- Reset:
  - Stimulus: rst_n low, then released with no hazards.
  - Required: all we=1, flushes=0, counters 0, dmem_req_o=0.
- Load-use:
  - Stimulus: idex_memread_i=1, idex_rt_i=5'd8, ifid_rs_i=5'd8.
  - Required: one cycle of pc_we_o=0, ifid_we_o=0, idex_flush_o=1, and stall_cnt_o=1.
  - Repeating with idex_rt_i=0 gives no stall.
- Branch taken:
  - Stimulus: exmem_branch_i=1, exmem_zero_i=1, with a simultaneous load-use match.
  - Required: pc_src_o=1, three flushes=1, all we=1, flush_cnt_o=1, no stall.
- Memory wait:
  - Stimulus: exmem_memread_i=1 with dmem_ready_i held 0 for 3 cycles, then 1.
  - Required: 4 cycles of all we=0 and dmem_req_o=1; state back to RUN; stall_cnt_o=4.
- Timeout:
  - Stimulus: MEM_TIMEOUT=15, dmem_ready_i never asserted.
  - Required: mem_err_o rises after the 15th wait cycle; dmem_req_o=0 and we=0 while in ERR.
  - Asserting rst_n=0 then clears mem_err_o.
- Saturation:
  - Stimulus: CNT_W=4, 20 load-use stalls.
  - Required: stall_cnt_o holds at 15.
